pipe_stage_skid: RTL and testbench

Generic, parametrised pipeline-stage register. It is the successor to the fixed ID/EX latch and is intended for any stage boundary: ID/EX, EX/MEM and MEM/WB.
- Carries a control bundle and a data bundle with a valid/ready handshake.
- A 2-entry skid buffer lets back-pressure from a downstream stall not combinationally reach upstream.
- A synchronous flush turns held instructions into bubbles.
- A saturating stall counter supports performance debug.

---
 rtl/pipe_stage_skid.sv | 129 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with a 2-entry skid buffer, synchronous flush
// and a saturating stall counter. in_ready is registered and never sees out_ready.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W     = 14,
  parameter int unsigned DATA_W     = 175,
  parameter int unsigned CLEAR_DATA = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {main_valid, skid_valid}; skid valid implies main valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b10,
    FULL2 = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic consume;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL2);
  assign accept     = in_valid & ~skid_valid;
  assign consume    = main_valid & out_ready;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cnt = stall_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Any concurrent accept is dropped; a concurrent consume needs no action here.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = FULL1;
          end
        end
        FULL1: begin
          if (consume && accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (consume) begin
            state_d = EMPTY;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = FULL2;
          end
        end
        FULL2: begin
          if (consume) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = FULL1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances (clearing flush with 4-bit counter,
// holding flush with 16-bit counter) driven identically and checked against a queue model.
module tb_pipe_stage_skid;

  localparam int unsigned CW = 14;
  localparam int unsigned DW = 175;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          flush;

  logic          c_in_ready, c_out_valid;
  logic [CW-1:0] c_out_ctrl;
  logic [DW-1:0] c_out_data;
  logic [1:0]    c_occ;
  logic [3:0]    c_stall;

  logic          h_in_ready, h_out_valid;
  logic [CW-1:0] h_out_ctrl;
  logic [DW-1:0] h_out_data;
  logic [1:0]    h_occ;
  logic [15:0]   h_stall;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_ctrl(c_out_ctrl), .out_data(c_out_data), .flush(flush), .occupancy(c_occ),
    .stall_cnt(c_stall)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(0), .CNT_W(16)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(h_out_valid), .out_ready(out_ready),
    .out_ctrl(h_out_ctrl), .out_data(h_out_data), .flush(flush), .occupancy(h_occ),
    .stall_cnt(h_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] got[$];
  int unsigned   st4, st16;
  int unsigned   checks, passes, fails;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_c_valid", c_out_valid, 0); chk("rst_c_ctrl", c_out_ctrl, 0);
    chk("rst_c_data", c_out_data, 0);   chk("rst_c_ready", c_in_ready, 1);
    chk("rst_c_occ", c_occ, 0);         chk("rst_c_stall", c_stall, 0);
    chk("rst_h_valid", h_out_valid, 0); chk("rst_h_ctrl", h_out_ctrl, 0);
    chk("rst_h_data", h_out_data, 0);   chk("rst_h_ready", h_in_ready, 1);
    chk("rst_h_occ", h_occ, 0);         chk("rst_h_stall", h_stall, 0);
  endtask

  task automatic check_outputs();
    int unsigned   n;
    logic [CW-1:0] ec;
    n  = q.size();
    ec = (n > 0) ? q[0].c : '0;
    chk("c_out_valid", c_out_valid, (n > 0)); chk("h_out_valid", h_out_valid, (n > 0));
    chk("c_out_ctrl", c_out_ctrl, ec);        chk("h_out_ctrl", h_out_ctrl, ec);
    if (n > 0) begin
      chk("c_out_data", c_out_data, q[0].d);
      chk("h_out_data", h_out_data, q[0].d);
    end
    chk("c_in_ready", c_in_ready, (n < 2));   chk("h_in_ready", h_in_ready, (n < 2));
    chk("c_occupancy", c_occ, n);             chk("h_occupancy", h_occ, n);
    chk("c_stall_cnt", c_stall, st4);         chk("h_stall_cnt", h_stall, st16);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                       input logic ordy, input logic fl);
    logic  acc, cons;
    beat_t b;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    out_ready = ~ordy;
    #1;
    chk("c_in_ready_vs_out_ready", c_in_ready, (q.size() < 2));
    chk("h_in_ready_vs_out_ready", h_in_ready, (q.size() < 2));
    out_ready = ordy;
    #1;
    if (c_out_valid && ordy) got.push_back(c_out_data);
    acc  = iv && (q.size() < 2);
    cons = (q.size() > 0) && ordy;
    if ((q.size() > 0) && !ordy) begin
      if (st4 < 15) st4++;
      if (st16 < 65535) st16++;
    end
    b.c = ic;
    b.d = id;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] a_val;
    checks = 0; passes = 0; fails = 0; st4 = 0; st16 = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) cycle(1'b1, 14'h3FFF, DW'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t1_count", got.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_order", (i < got.size()) ? got[i] : '0, i + 1);
    chk("t1_stall", c_stall, 0);

    // Back-pressure into the skid entry
    got.delete();
    cycle(1'b1, 14'h3FFF, DW'('hA), 1'b1, 1'b0);
    cycle(1'b1, 14'h3FFF, DW'('hB), 1'b0, 1'b0);
    cycle(1'b1, 14'h3FFF, DW'('hC), 1'b0, 1'b0);
    chk("t2_in_ready_full", c_in_ready, 0);
    chk("t2_occ_full", c_occ, 2);
    cycle(1'b1, 14'h3FFF, DW'('hC), 1'b0, 1'b0);
    cycle(1'b1, 14'h3FFF, DW'('hC), 1'b1, 1'b0);
    cycle(1'b1, 14'h3FFF, DW'('hC), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t2_count", got.size(), 3);
    chk("t2_first", (got.size() > 0) ? got[0] : '0, 'hA);
    chk("t2_second", (got.size() > 1) ? got[1] : '0, 'hB);
    chk("t2_third", (got.size() > 2) ? got[2] : '0, 'hC);
    chk("t2_stall", c_stall, 3);

    // Flush from FULL2 with a concurrent offered beat
    got.delete();
    cycle(1'b1, 14'h3FFF, DW'('hA), 1'b0, 1'b0);
    cycle(1'b1, 14'h3FFF, DW'('hB), 1'b0, 1'b0);
    cycle(1'b1, 14'h3FFF, DW'('hD), 1'b0, 1'b1);
    chk("t3_c_valid", c_out_valid, 0);  chk("t3_c_ctrl", c_out_ctrl, 0);
    chk("t3_c_occ", c_occ, 0);          chk("t3_c_ready", c_in_ready, 1);
    chk("t3_c_data_cleared", c_out_data, 0);
    chk("t3_h_ctrl", h_out_ctrl, 0);
    chk("t3_h_data_held", h_out_data, 'hA);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t3_nothing_emerges", got.size(), 0);

    // Flush and consume in the same cycle
    got.delete();
    cycle(1'b1, 14'h1234, DW'('hE), 1'b1, 1'b0);
    cycle(1'b1, 14'h1234, DW'('hF), 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t4_count", got.size(), 1);
    chk("t4_beat", (got.size() > 0) ? got[0] : '0, 'hE);

    // Stall counter saturation, flush immunity, asynchronous reset
    a_val = 'h5;
    cycle(1'b1, 14'h3FFF, a_val, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t5_saturated", c_stall, 15);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("t5_after_flush", c_stall, 15);
    cycle(1'b1, 14'h3FFF, DW'('h6), 1'b0, 1'b0);
    cycle(1'b1, 14'h3FFF, DW'('h7), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    q.delete(); st4 = 0; st16 = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 99) < 70), CW'($urandom), rnd_data(),
            ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 3));
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t6_drained_valid", c_out_valid, 0);
    chk("t6_drained_occ", h_occ, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
